memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Memory (M) stage plus MEM/WB pipeline register of the 5-stage RV32I core. Consumes the EX/MEM register outputs.
//  Performs byte/half/word loads and stores over a req/ready data-memory handshake, and sign/zero-extends load data.
//  Stalls upstream while an access is outstanding and registers results into the W stage.
// PARAMETERS
//  WIDTH    32  datapath/address width (only 32 supported for byte-enable logic)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  RegWriteM    in   1      register write enable from EX/MEM
//  ResultSrcM   in   2      00=ALU, 01=load, 10=PC+4
//  MemWriteM    in   1      store enable
//  Funct3M      in   3      000 b, 001 h, 010 w, 100 bu, 101 hu
//  ALUResultM   in   WIDTH  effective address / ALU result
//  WriteDataM   in   WIDTH  store data (unaligned, lane 0)
//  RdM          in   5      destination register
//  PCPlus4M     in   WIDTH  PC+4
//  dmem_req     out  1      access request
//  dmem_we      out  1      1=store, 0=load
//  dmem_addr    out  WIDTH  word-aligned address ({ALUResultM[31:2],2'b00})
//  dmem_wdata   out  WIDTH  store data replicated into lanes
//  dmem_be      out  4      byte enables
//  dmem_rdata   in   WIDTH  load data, valid when dmem_ready
//  dmem_ready   in   1      access completes this cycle
//  StallM       out  1      hold F/D/E stages and EX/MEM register
//  RegWriteW, ResultSrcW[2], ALUResultW, ReadDataW, RdW[5], PCPlus4W   out   MEM/WB register
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all W outputs 0; dmem_req=0; StallM=0.
//  - Access = MemWriteM | (ResultSrcM==01). Non-access: W regs load M inputs next edge, ReadDataW=0.
//  - FSM IDLE: on access drive dmem_req=1 combinationally. If dmem_ready same cycle -> complete, zero stall.
//    Otherwise -> WAIT, StallM=1.
//  - FSM WAIT: dmem_req, we, addr, wdata, be held stable (driven from latched copies). StallM=1 until
//    dmem_ready. On ready: complete, StallM=0 that cycle, -> IDLE.
//  - Complete: W regs capture M fields; ReadDataW=extended load data (stores: 0).
//  - While StallM=1 and not completing: W gets bubble (RegWriteW=0, RdW=0); other W fields hold.
//  - Byte enables: b -> 0001<<addr[1:0]; h -> 0011<<{addr[1],1'b0}; w -> 1111. Stores: wdata = byte
//    replicated x4 / half x2 / word.
//  - Load extract: select lane by addr[1:0]; b/h sign-extend, bu/hu zero-extend, w as-is.
//  - Misaligned (h with addr[0]=1, w with addr[1:0]!=0): be masked to 0000, request still issued.
//  - dmem_ready while dmem_req=0: ignored.
//  - Reset mid-WAIT: aborts to IDLE, dmem_req drops asynchronously.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: adds output MisalignW (1). Misaligned access issues no request
//    (dmem_req=0, no stall), W gets RegWriteW=0, MisalignW=1 for one cycle, RdW=RdM, ALUResultW=address.
//    MisalignW resets to 0.
//  Undefined: no port; misaligned handled as above (be=0000, load returns extended masked data).
// TESTING
//  - Reset: rst_n=0 mid-WAIT -> dmem_req=0, StallM=0, all W outputs 0 immediately.
//  - sb: addr=0x1003, data=0x000000A5, ready same cycle -> be=1000, wdata=0xA5A5A5A5, StallM never 1.
//  - lb: addr=0x2001, rdata=0x0000_80_00, ready after 3 cycles -> StallM=1 for 3 cycles, be=0010,
//    W bubbles x3, then ReadDataW=0xFFFFFF80, RegWriteW=1.
//  - lhu: addr=0x2002, rdata=0xBEEF1234 -> ReadDataW=0x0000BEEF.
//  - Back-to-back ALU op then sw (ready=1): ALU result reaches ALUResultW, then sw drives be=1111.
//    No bubble.
//  - lw addr=0x3002 with MEM_MISALIGN_TRAP_EN: dmem_req=0, MisalignW=1, RegWriteW=0, no stall.

Source files
------------

// File: rtl/memory_stage.sv
// Memory (M) stage and MEM/WB pipeline register of the 5-stage RV32I core.
// Issues byte/half/word loads and stores over a req/ready data-memory port.
// Load data is sign- or zero-extended. Upstream stages are held with StallM
// while an access is outstanding.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// accesses issue no request and raise MisalignW for one cycle instead.
// WIDTH must be 32, because the byte-lane logic assumes four lanes.
module memory_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [4:0]       RdM,
  input  logic [WIDTH-1:0] PCPlus4M,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ready,
  output logic             StallM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [4:0]       RdW,
  output logic [WIDTH-1:0] PCPlus4W
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic             MisalignW
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             access, is_byte, is_half, misalign_m, trap_m;
  logic             in_wait, req_raw, stall_raw, complete;
  logic [3:0]       be_m;
  logic [WIDTH-1:0] addr_m, wdata_m;

  // Request attributes latched while idle, so they stay stable during WAIT
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;

  logic [2:0]       funct3_sel;
  logic [1:0]       off_sel;
  logic [WIDTH-1:0] rdata_masked, rdata_shift, load_ext;

  // MEM/WB register
  logic             reg_write_w_q, reg_write_w_d;
  logic [1:0]       result_src_w_q, result_src_w_d;
  logic [WIDTH-1:0] alu_result_w_q, alu_result_w_d;
  logic [WIDTH-1:0] read_data_w_q, read_data_w_d;
  logic [4:0]       rd_w_q, rd_w_d;
  logic [WIDTH-1:0] pc_plus4_w_q, pc_plus4_w_d;
  logic             misalign_w_q, misalign_w_d;

  // Decode the M-stage access: size, alignment, lane enables and replicated store data
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    be_m       = 4'b0000;
    wdata_m    = WriteDataM;
    access     = MemWriteM | (ResultSrcM == 2'b01);
    is_byte    = (Funct3M[1:0] == 2'b00);
    is_half    = (Funct3M[1:0] == 2'b01);
    misalign_m = (is_half & ALUResultM[0]) |
                 (~is_byte & ~is_half & (ALUResultM[1:0] != 2'b00));
    addr_m     = {ALUResultM[WIDTH-1:2], 2'b00};
    if (is_byte) begin
      be_m    = 4'b0001 << ALUResultM[1:0];
      wdata_m = {4{WriteDataM[7:0]}};
    end else if (is_half) begin
      be_m    = 4'b0011 << {ALUResultM[1], 1'b0};
      wdata_m = {2{WriteDataM[15:0]}};
    end else begin
      be_m    = 4'b1111;
    end
    if (misalign_m) be_m = 4'b0000;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_m = (state_q == S_IDLE) & access & misalign_m;
`else
  assign trap_m = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments, so all flops sample pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: park in WAIT until the memory answers
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_raw && !dmem_ready) state_d = S_WAIT;
      S_WAIT: if (dmem_ready)             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request/stall raw values (reset forces both low asynchronously)
  always_comb begin
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_raw   = access & ~trap_m;
        stall_raw = req_raw & ~dmem_ready;
      end
      S_WAIT: begin
        req_raw   = 1'b1;
        stall_raw = ~dmem_ready;
      end
      default: ;
    endcase
  end

  assign in_wait  = (state_q == S_WAIT);
  assign complete = req_raw & dmem_ready;
  assign dmem_req = req_raw & rst_n;
  assign StallM   = stall_raw & rst_n;

  // Memory bus: live decode when idle, latched copies while waiting
  always_comb begin
    dmem_we    = in_wait ? we_q    : MemWriteM;
    dmem_addr  = in_wait ? addr_q  : addr_m;
    dmem_wdata = in_wait ? wdata_q : wdata_m;
    dmem_be    = in_wait ? be_q    : be_m;
  end

  // Capture request attributes every idle cycle; hold them while waiting
  always_comb begin
    addr_d   = in_wait ? addr_q   : addr_m;
    wdata_d  = in_wait ? wdata_q  : wdata_m;
    we_d     = in_wait ? we_q     : MemWriteM;
    be_d     = in_wait ? be_q     : be_m;
    funct3_d = in_wait ? funct3_q : Funct3M;
    off_d    = in_wait ? off_q    : ALUResultM[1:0];
  end

  // Latched request attributes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      be_q     <= be_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
    end
  end

  // Load extraction: disabled lanes read as zero, then shift the addressed lane down and extend it
  always_comb begin
    funct3_sel = in_wait ? funct3_q : Funct3M;
    off_sel    = in_wait ? off_q    : ALUResultM[1:0];
    for (int i = 0; i < 4; i++) begin
      rdata_masked[8*i +: 8] = dmem_rdata[8*i +: 8] & {8{dmem_be[i]}};
    end
    rdata_shift = rdata_masked >> {off_sel, 3'b000};
    unique case (funct3_sel[1:0])
      2'b00:   load_ext = funct3_sel[2] ? {24'b0, rdata_shift[7:0]}
                                        : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_ext = funct3_sel[2] ? {16'b0, rdata_shift[15:0]}
                                        : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  // MEM/WB next value: trap, bubble while stalled, or capture the M fields
  always_comb begin
    reg_write_w_d  = reg_write_w_q;
    result_src_w_d = result_src_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    rd_w_d         = rd_w_q;
    pc_plus4_w_d   = pc_plus4_w_q;
    misalign_w_d   = 1'b0;
    if (trap_m) begin
      reg_write_w_d  = 1'b0;
      result_src_w_d = ResultSrcM;
      alu_result_w_d = ALUResultM;
      read_data_w_d  = '0;
      rd_w_d         = RdM;
      pc_plus4_w_d   = PCPlus4M;
      misalign_w_d   = 1'b1;
    end else if (stall_raw) begin
      reg_write_w_d  = 1'b0;
      rd_w_d         = 5'd0;
    end else begin
      reg_write_w_d  = RegWriteM;
      result_src_w_d = ResultSrcM;
      alu_result_w_d = ALUResultM;
      read_data_w_d  = (complete & ~dmem_we) ? load_ext : '0;
      rd_w_d         = RdM;
      pc_plus4_w_d   = PCPlus4M;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 2'b00;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      rd_w_q         <= 5'd0;
      pc_plus4_w_q   <= '0;
      misalign_w_q   <= 1'b0;
    end else begin
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      rd_w_q         <= rd_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      misalign_w_q   <= misalign_w_d;
    end
  end

  assign RegWriteW  = reg_write_w_q;
  assign ResultSrcW = result_src_w_q;
  assign ALUResultW = alu_result_w_q;
  assign ReadDataW  = read_data_w_q;
  assign RdW        = rd_w_q;
  assign PCPlus4W   = pc_plus4_w_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign MisalignW = misalign_w_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_w_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a transaction-level model predicts the bus,
// the stall and the MEM/WB register on every cycle. Directed cases are followed by random traffic.
module tb_memory_stage;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } instr_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        mis;
  } wb_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        RegWriteM = 0, MemWriteM = 0, dmem_ready = 0;
  logic [1:0]  ResultSrcM = 0;
  logic [2:0]  Funct3M = 0;
  logic [31:0] ALUResultM = 0, WriteDataM = 0, PCPlus4M = 0, dmem_rdata = 0;
  logic [4:0]  RdM = 0;
  logic        dmem_req, dmem_we, StallM, RegWriteW;
  logic [31:0] dmem_addr, dmem_wdata, ALUResultW, ReadDataW, PCPlus4W;
  logic [3:0]  dmem_be;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  int n_tests = 0, n_fail = 0, stall_cnt = 0;
  logic chk_en = 1'b0;
  logic exp_req = 0, exp_stall = 0, exp_we = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_be = 0;
  wb_t exp_w = '0;

  memory_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
`ifdef MEM_MISALIGN_TRAP_EN
    , .MisalignW(MisalignW)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic misal(input instr_t i);
    return (int'(i.alu[1:0]) % nbytes(i.f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input instr_t i);
    int n = nbytes(i.f3);
    if (misal(i)) return 4'b0000;
    return 4'(((1 << n) - 1) << int'(i.alu[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input instr_t i);
    logic [31:0] r;
    int n = nbytes(i.f3);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = i.wd[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input instr_t i, input logic [31:0] rdata);
    logic [63:0] v, mask;
    int n = nbytes(i.f3);
    if (misal(i)) return 32'h0;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = ({32'b0, rdata} >> (8 * int'(i.alu[1:0]))) & mask;
    if (!i.f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic instr_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] rd,
                                input logic [31:0] pc4);
    instr_t i;
    i.rw = rw; i.rs = rs; i.mw = mw; i.f3 = f3;
    i.alu = alu; i.wd = wd; i.rd = rd; i.pc4 = pc4;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int kind = $urandom_range(0, 3);
    i = mk(1'($urandom), 2'b00, 1'b0, 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
    case (kind)
      1: i.rs = 2'b10;
      2: begin i.rs = 2'b01; i.rw = 1'b1; i.f3 = ld_f3[$urandom_range(0, 4)]; end
      3: begin i.mw = 1'b1; i.rw = 1'b0; i.f3 = 3'($urandom_range(0, 2)); end
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) i.alu[1:0] = 2'b00;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    RegWriteM = i.rw; ResultSrcM = i.rs; MemWriteM = i.mw; Funct3M = i.f3;
    ALUResultM = i.alu; WriteDataM = i.wd; RdM = i.rd; PCPlus4M = i.pc4;
  endtask

  // Present one instruction (starting at posedge+1) and hold it until the model says it retires.
  task automatic issue(input instr_t ins, input int lat, input logic [31:0] rdata);
    logic acc, trap;
    int ncyc;
    acc  = ins.mw || (ins.rs == 2'b01);
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = acc && misal(ins);
`endif
    ncyc = (acc && !trap) ? lat : 0;
    drive(ins);
    for (int k = 0; k <= ncyc; k++) begin
      if (acc && !trap) begin
        dmem_ready = (k == lat);
        dmem_rdata = (k == lat) ? rdata : $urandom;
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      exp_req   = acc && !trap;
      exp_stall = exp_req && (k < lat);
      exp_we    = ins.mw;
      exp_addr  = {ins.alu[31:2], 2'b00};
      exp_wdata = m_wdata(ins);
      exp_be    = m_be(ins);
      @(posedge clk); #1;
      if (trap) begin
        exp_w = '{rw: 1'b0, rs: ins.rs, alu: ins.alu, rdata: 32'h0, rd: ins.rd, pc4: ins.pc4, mis: 1'b1};
      end else if (exp_stall) begin
        exp_w.rw = 1'b0; exp_w.rd = 5'd0; exp_w.mis = 1'b0;
      end else begin
        exp_w = '{rw: ins.rw, rs: ins.rs, alu: ins.alu,
                  rdata: (acc && !ins.mw) ? m_load(ins, rdata) : 32'h0,
                  rd: ins.rd, pc4: ins.pc4, mis: 1'b0};
      end
    end
    dmem_ready = 1'b0;
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (StallM) stall_cnt++;
      check("dmem_req", 32'(dmem_req), 32'(exp_req));
      check("StallM", 32'(StallM), 32'(exp_stall));
      if (exp_req) begin
        check("dmem_we", 32'(dmem_we), 32'(exp_we));
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_be", 32'(dmem_be), 32'(exp_be));
        if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      check("RegWriteW", 32'(RegWriteW), 32'(exp_w.rw));
      check("ResultSrcW", 32'(ResultSrcW), 32'(exp_w.rs));
      check("ALUResultW", ALUResultW, exp_w.alu);
      check("ReadDataW", ReadDataW, exp_w.rdata);
      check("RdW", 32'(RdW), 32'(exp_w.rd));
      check("PCPlus4W", PCPlus4W, exp_w.pc4);
`ifdef MEM_MISALIGN_TRAP_EN
      check("MisalignW", 32'(MisalignW), 32'(exp_w.mis));
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t i0;
    instr_t nop;
    nop = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_stall", 32'(StallM), 32'h0);
    check("rst_RegWriteW", 32'(RegWriteW), 32'h0);
    check("rst_ReadDataW", ReadDataW, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Model pins: hand-computed lane/extension results
    i0 = mk(1'b0, 2'b00, 1'b1, 3'b000, 32'h1003, 32'h000000A5, 5'd0, 32'h4);
    check("model_sb_be", 32'(m_be(i0)), 32'h8);
    check("model_sb_wdata", m_wdata(i0), 32'hA5A5A5A5);
    check("model_lb_ext", m_load(mk(1, 2'b01, 0, 3'b000, 32'h2001, 0, 1, 0), 32'h00008000), 32'hFFFFFF80);
    check("model_lhu_ext", m_load(mk(1, 2'b01, 0, 3'b101, 32'h2002, 0, 1, 0), 32'hBEEF1234), 32'h0000BEEF);
    check("model_sh_mis_be", 32'(m_be(mk(0, 2'b00, 1, 3'b001, 32'h11, 0, 0, 0))), 32'h0);

    // sb with ready in the same cycle: no stall
    stall_cnt = 0;
    issue(i0, 0, 32'h0);
    check("sb_stall_cycles", 32'(stall_cnt), 32'd0);

    // lb with ready after 3 cycles
    stall_cnt = 0;
    issue(mk(1'b1, 2'b01, 1'b0, 3'b000, 32'h2001, 32'h0, 5'd7, 32'h108), 3, 32'h00008000);
    check("lb_stall_cycles", 32'(stall_cnt), 32'd3);
    check("lb_ReadDataW", ReadDataW, 32'hFFFFFF80);
    check("lb_RegWriteW", 32'(RegWriteW), 32'h1);
    check("lb_RdW", 32'(RdW), 32'd7);

    // lhu
    issue(mk(1'b1, 2'b01, 1'b0, 3'b101, 32'h2002, 32'h0, 5'd9, 32'h10C), 1, 32'hBEEF1234);
    check("lhu_ReadDataW", ReadDataW, 32'h0000BEEF);

    // ALU op then sw with ready, no bubble
    stall_cnt = 0;
    issue(mk(1'b1, 2'b00, 1'b0, 3'b000, 32'h12345678, 32'h0, 5'd3, 32'h110), 0, 32'h0);
    check("alu_ALUResultW", ALUResultW, 32'h12345678);
    check("alu_RegWriteW", 32'(RegWriteW), 32'h1);
    issue(mk(1'b0, 2'b00, 1'b1, 3'b010, 32'h00000040, 32'hCAFEF00D, 5'd0, 32'h114), 0, 32'h0);
    check("sw_stall_cycles", 32'(stall_cnt), 32'd0);

    // Misaligned lw
    stall_cnt = 0;
    issue(mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h3002, 32'h0, 5'd5, 32'h118), 1, 32'hFFFFFFFF);
    check("mis_ReadDataW", ReadDataW, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_trap_flag", 32'(MisalignW), 32'h1);
    check("mis_trap_stall", 32'(stall_cnt), 32'd0);
    check("mis_trap_rd", 32'(RdW), 32'd5);
`endif

    // Reset in the middle of a WAIT
    i0 = mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd12, 32'h11C);
    drive(i0);
    dmem_ready = 1'b0;
    exp_req = 1'b1; exp_stall = 1'b1; exp_we = 1'b0;
    exp_addr = 32'h4000; exp_be = m_be(i0); exp_wdata = m_wdata(i0);
    repeat (2) begin
      @(posedge clk); #1;
      exp_w.rw = 1'b0; exp_w.rd = 5'd0; exp_w.mis = 1'b0;
    end
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_req", 32'(dmem_req), 32'h0);
    check("abort_stall", 32'(StallM), 32'h0);
    check("abort_RegWriteW", 32'(RegWriteW), 32'h0);
    check("abort_ResultSrcW", 32'(ResultSrcW), 32'h0);
    check("abort_ALUResultW", ALUResultW, 32'h0);
    check("abort_RdW", 32'(RdW), 32'h0);
    check("abort_PCPlus4W", PCPlus4W, 32'h0);
    drive(nop);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_w = '0; exp_req = 1'b0; exp_stall = 1'b0;
    chk_en = 1'b1;

    // Random traffic with random memory latency
    for (int n = 0; n < 400; n++) begin
      issue(rand_instr(), $urandom_range(0, 3), $urandom);
    end

    drive(nop);
    issue(nop, 0, 32'h0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
